// File: rtl/timer_bank.sv
// Bank of independent countdown channels decremented by a free-running 1 Hz tick.
// Optional macro TIMER_BANK_BLINK_EN adds a per-channel blink output driven while a channel is expired.
module timer_bank #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int CHANNELS = 4,
  parameter int COUNT_W  = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [CHANNELS-1:0]           start,
  input  logic [CHANNELS-1:0]           cancel,
  input  logic [CHANNELS-1:0]           pause,
  input  logic [CHANNELS*COUNT_W-1:0]   value,
  output logic                          tick_1hz,
  output logic                          tick_2hz,
  output logic [CHANNELS*COUNT_W-1:0]   count,
  output logic [CHANNELS-1:0]           running,
  output logic [CHANNELS-1:0]           expired,
  output logic [CHANNELS-1:0]           expire_pulse
`ifdef TIMER_BANK_BLINK_EN
  ,
  output logic [CHANNELS-1:0]           blink
`endif
);

  localparam int HALF_HZ = CLK_HZ / 2;
  localparam int DIV1_W  = $clog2(CLK_HZ);
  localparam int DIV2_W  = $clog2(HALF_HZ);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  logic [DIV1_W-1:0] div1_reg;
  logic [DIV2_W-1:0] div2_reg;
  logic              tick1_reg;
  logic              tick2_reg;

  // Ticks are registered one count early so they are high exactly while the divider sits at its last value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div1_reg  <= '0;
      div2_reg  <= '0;
      tick1_reg <= 1'b0;
      tick2_reg <= 1'b0;
    end else begin
      div1_reg  <= (div1_reg == DIV1_W'(CLK_HZ - 1)) ? '0 : div1_reg + 1'b1;
      div2_reg  <= (div2_reg == DIV2_W'(HALF_HZ - 1)) ? '0 : div2_reg + 1'b1;
      tick1_reg <= (div1_reg == DIV1_W'(CLK_HZ - 2));
      tick2_reg <= (div2_reg == DIV2_W'(HALF_HZ - 2));
    end
  end

  assign tick_1hz = tick1_reg;
  assign tick_2hz = tick2_reg;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      state_t             state_reg, state_next;
      logic [COUNT_W-1:0] count_reg, count_next, load_val;
      logic               pulse_reg, pulse_next;
      logic               running_reg, expired_reg;

      assign load_val = value[gi*COUNT_W +: COUNT_W];

      // Priority: start > cancel > pause > tick.
      always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        pulse_next = 1'b0;
        if (start[gi]) begin
          count_next = load_val;
          if (load_val == '0) begin
            state_next = EXPIRED;
            pulse_next = 1'b1;
          end else begin
            state_next = pause[gi] ? PAUSE : RUN;
          end
        end else if (cancel[gi]) begin
          state_next = IDLE;
          count_next = '0;
        end else begin
          case (state_reg)
            RUN: begin
              if (pause[gi]) begin
                state_next = PAUSE;
              end else if (tick1_reg && count_reg != '0) begin
                count_next = count_reg - 1'b1;
                if (count_reg == COUNT_W'(1)) begin
                  state_next = EXPIRED;
                  pulse_next = 1'b1;
                end
              end
            end
            PAUSE:   if (!pause[gi]) state_next = RUN;
            EXPIRED: count_next = '0;
            default: ;
          endcase
        end
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          state_reg   <= IDLE;
          count_reg   <= '0;
          pulse_reg   <= 1'b0;
          running_reg <= 1'b0;
          expired_reg <= 1'b0;
        end else begin
          state_reg   <= state_next;
          count_reg   <= count_next;
          pulse_reg   <= pulse_next;
          running_reg <= (state_next == RUN) || (state_next == PAUSE);
          expired_reg <= (state_next == EXPIRED);
        end
      end

      assign count[gi*COUNT_W +: COUNT_W] = count_reg;
      assign running[gi]      = running_reg;
      assign expired[gi]      = expired_reg;
      assign expire_pulse[gi] = pulse_reg;

`ifdef TIMER_BANK_BLINK_EN
      logic blink_reg;

      // Blink starts low on entry to EXPIRED and flips on each half-second tick while there.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          blink_reg <= 1'b0;
        end else if (state_next == EXPIRED) begin
          if (state_reg == EXPIRED && tick2_reg) blink_reg <= ~blink_reg;
        end else begin
          blink_reg <= 1'b0;
        end
      end

      assign blink[gi] = blink_reg;
`endif
    end
  endgenerate

endmodule

// File: doc/timer_bank.md
TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, input clock frequency in Hz (even, >=4).
REQ-002 SHALL have parameter CHANNELS, default 4, number of independent countdown channels (1..16).
REQ-003 SHALL have parameter COUNT_W, default 4, width of each channel count.
REQ-004 SHALL have port clock  input  1  system clock, rising-edge active.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  CHANNELS  per-channel one-cycle load/start strobe.
REQ-007 SHALL have port cancel  input  CHANNELS  per-channel one-cycle abort strobe.
REQ-008 SHALL have port pause  input  CHANNELS  per-channel level; 1 = hold count.
REQ-009 SHALL have port value  input  CHANNELS*COUNT_W  per-channel load values; channel i at bits [i*COUNT_W +: COUNT_W].
REQ-010 SHALL have port tick_1hz  output  1  one-cycle pulse once per second.
REQ-011 SHALL have port tick_2hz  output  1  one-cycle pulse twice per second.
REQ-012 SHALL have port count  output  CHANNELS*COUNT_W  per-channel current counts, packed as value.
REQ-013 SHALL have port running  output  CHANNELS  1 while channel is in RUN or PAUSE.
REQ-014 SHALL have port expired  output  CHANNELS  level, 1 while channel is in EXPIRED.
REQ-015 SHALL have port expire_pulse  output  CHANNELS  one-cycle pulse on entry to EXPIRED.

Function
REQ-016 Tick dividers SHALL be free-running: the 1 Hz counter counts 0..CLK_HZ-1, and tick_1hz is 1 for exactly the cycle in which the counter equals CLK_HZ-1, then wraps to 0; the 2 Hz divider does the same with CLK_HZ/2.
REQ-017 Dividers SHALL NOT be restarted by start, cancel or pause; the first decrement after start occurs within 1 s.
REQ-018 Each channel SHALL implement states IDLE, RUN, PAUSE, EXPIRED; all channels are identical and independent.
REQ-019 start[i] SHALL load count[i]=value[i] on the next edge and go to RUN (PAUSE if pause[i]=1); if value[i]=0 it SHALL go directly to EXPIRED and pulse expire_pulse[i].
REQ-020 In RUN, tick_1hz SHALL decrement count by 1; the decrement from 1 to 0 SHALL enter EXPIRED on the same edge, with expire_pulse asserted for the following cycle.
REQ-021 RUN->PAUSE when pause[i]=1; PAUSE->RUN when pause[i]=0; count holds in PAUSE, and a tick coinciding with pause=1 SHALL NOT decrement.
REQ-022 cancel[i] SHALL return the channel to IDLE with count 0, expired 0, from any state.
REQ-023 Priority per channel SHALL be start > cancel > pause > tick; start together with cancel SHALL load.
REQ-024 EXPIRED SHALL hold count=0 and expired=1 until start or cancel; start in EXPIRED SHALL reload.
REQ-025 count SHALL never underflow; no wrap below 0.
REQ-026 All outputs SHALL be registered; latency from strobe to output change SHALL be 1 clock.

Reset
REQ-027 Reset SHALL force dividers to 0, ticks 0, all channels IDLE, count 0, running 0, expired 0, expire_pulse 0.
REQ-028 Reset asserted mid-count SHALL abort all channels; after release, channels SHALL remain IDLE until a new start.

Configuration
REQ-029 Macro TIMER_BANK_BLINK_EN, when defined, SHALL add output blink [CHANNELS], which toggles on each tick_2hz while the channel is in EXPIRED and is 0 otherwise (reset 0, cleared on leaving EXPIRED).
REQ-030 When TIMER_BANK_BLINK_EN is undefined, the blink port and its logic SHALL be absent; all other behaviour is unchanged.

Verification (CLK_HZ=8, CHANNELS=2, COUNT_W=4)
REQ-031 Free run after reset -> tick_1hz high once every 8 cycles, tick_2hz high once every 4 cycles, each 1 cycle wide.
REQ-032 start[0] with value=3 -> count 3,2,1,0 on successive tick_1hz; expired[0]=1 and a single expire_pulse[0] at 0; channel 1 unaffected.
REQ-033 value=0 with start -> expired=1 and expire_pulse one cycle after start; running stays 0.
REQ-034 pause[1]=1 across two ticks mid-count at 5 -> count holds 5; on release, decrements resume on the next tick.
REQ-035 start and cancel in the same cycle -> load wins; cancel alone during RUN -> count 0, running 0, no expire_pulse.
REQ-036 Reset asserted with both channels at count 2 -> all outputs 0 asynchronously, and no activity until a new start; with the macro defined, blink toggles every 4 cycles in EXPIRED.
